// File: rtl/wav_chan_mixer.sv
// wav_chan_mixer: mixes NCH unsigned 8-bit sample streams (0x80 = silence)
// into one unsigned offset-binary 16-bit word. Each channel is scaled by its
// 4-bit volume. The channels are summed one per clock, then gained and
// saturated. The output is refreshed once every DIV+1 clocks.
module wav_chan_mixer #(
  parameter int NCH     = 4,
  parameter int DIV     = 2177,
  parameter int GAIN_SH = 3
) (
  input  logic             I_CLK,
  input  logic             I_RSTn,
  input  logic [NCH*8-1:0] I_SMP,
  input  logic [NCH-1:0]   I_SMP_VLD,
  input  logic [NCH*4-1:0] I_VOL,
  input  logic             I_MUTE,
  output logic [15:0]      O_SND,
  output logic             O_SND_VLD,
  output logic             O_CLIP,
  output logic             O_BUSY
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  // 9-bit signed sample times 4-bit volume fits 13 bits; add headroom for NCH terms
  localparam int ACC_W = 13 + $clog2(NCH);
  // wide enough that the gained sum can never wrap before it is clamped
  localparam int SAT_W = ACC_W + GAIN_SH + 17;

  localparam logic signed [SAT_W-1:0] MAXV = SAT_W'(32767);
  localparam logic signed [SAT_W-1:0] MINV = -SAT_W'(32768);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT, S_OUT} state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      tick;
  logic [NCH*8-1:0]          hold_q;
  logic [NCH*8-1:0]          snap_q;
  logic [IDX_W-1:0]          idx_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic [15:0]               snd_q;
  logic                      vld_q;
  logic                      clip_q;
  logic                      busy_q;

  logic [7:0]                smp_sel;
  logic [3:0]                vol_sel;
  logic signed [8:0]         diff;
  logic signed [12:0]        prod;
  logic signed [SAT_W-1:0]   gained;

  // clamp a gained sum into the signed 16-bit output range
  function automatic logic signed [15:0] sat16(input logic signed [SAT_W-1:0] v);
    if (v > MAXV)      return 16'sh7fff;
    else if (v < MINV) return 16'sh8000;
    else               return v[15:0];
  endfunction

  // report whether sat16 had to clamp this value
  function automatic logic sat_clip(input logic signed [SAT_W-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  assign tick      = (cnt_q == CNT_W'(DIV));
  assign O_SND     = snd_q;
  assign O_SND_VLD = vld_q;
  assign O_CLIP    = clip_q;
  assign O_BUSY    = busy_q;

  // output-period divider: 0..DIV, tick on the last count
  always_ff @(posedge I_CLK) begin
    if (!I_RSTn)   cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  // per-channel hold registers, loaded by their strobe in any state
  always_ff @(posedge I_CLK) begin
    if (!I_RSTn) begin
      hold_q <= {NCH{8'h80}};
    end else begin
      for (int k = 0; k < NCH; k++)
        if (I_SMP_VLD[k]) hold_q[8*k +: 8] <= I_SMP[8*k +: 8];
    end
  end

  // pick the channel being accumulated and form its signed, scaled term
  always_comb begin
    smp_sel = 8'h80;
    vol_sel = 4'd0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        smp_sel = snap_q[8*k +: 8];
        vol_sel = I_VOL[4*k +: 4];
      end
    end
    diff   = $signed({1'b0, smp_sel}) - 9'sd128;
    prod   = 13'(diff) * $signed({9'b0, vol_sel});
    acc_d  = acc_q + ACC_W'(prod);
    gained = SAT_W'(acc_q) <<< GAIN_SH;
  end

  // mixing sequencer with registered outputs; a tick outside IDLE is ignored
  always_ff @(posedge I_CLK) begin
    if (!I_RSTn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      snd_q   <= 16'h8000;
      vld_q   <= 1'b0;
      clip_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            snap_q  <= hold_q;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          acc_q <= acc_d;
          if (idx_q == IDX_W'(NCH - 1)) state_q <= S_SAT;
          else                          idx_q   <= idx_q + 1'b1;
        end
        S_SAT: begin
          // output lands together with the pulse, visible during OUT
          if (I_MUTE) begin
            snd_q <= 16'h8000;
          end else begin
            snd_q  <= sat16(gained) ^ 16'h8000;
            clip_q <= clip_q | sat_clip(gained);
          end
          vld_q   <= 1'b1;
          state_q <= S_OUT;
        end
        S_OUT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wav_chan_mixer.sv
// Bench for wav_chan_mixer: queue-based scoreboard with a behavioural mix model.
module tb_wav_chan_mixer;

  localparam int NCH     = 4;
  localparam int DIV     = 2177;
  localparam int GAIN_SH = 3;
  localparam int LAT     = NCH + 2;

  logic             clk = 1'b0;
  logic             I_RSTn = 1'b0;
  logic [NCH*8-1:0] I_SMP = '0;
  logic [NCH-1:0]   I_SMP_VLD = '0;
  logic [NCH*4-1:0] I_VOL = '0;
  logic             I_MUTE = 1'b0;
  logic [15:0]      O_SND;
  logic             O_SND_VLD;
  logic             O_CLIP;
  logic             O_BUSY;

  typedef struct {
    logic [15:0] snd;
    logic        clip;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         since_rst = 0;
  int         pops = 0;
  bit         mon_en = 0;
  logic [7:0] hold_m[NCH];
  logic [3:0] vol_m[NCH];
  bit         mute_m = 0;
  bit         clip_m = 0;

  wav_chan_mixer #(.NCH(NCH), .DIV(DIV), .GAIN_SH(GAIN_SH)) dut (
    .I_CLK(clk), .I_RSTn(I_RSTn), .I_SMP(I_SMP), .I_SMP_VLD(I_SMP_VLD),
    .I_VOL(I_VOL), .I_MUTE(I_MUTE), .O_SND(O_SND), .O_SND_VLD(O_SND_VLD),
    .O_CLIP(O_CLIP), .O_BUSY(O_BUSY)
  );

  always #5 clk = ~clk;

  // cycles since the last reset edge; cycle 0 is the first one after it
  always @(posedge clk) since_rst <= I_RSTn ? since_rst + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: every cycle where a pulse is due or seen is checked
  always @(negedge clk) begin
    if (mon_en) begin
      automatic bit exp_vld = (since_rst >= DIV + LAT) &&
                              (((since_rst - (DIV + LAT)) % (DIV + 1)) == 0);
      if (exp_vld || O_SND_VLD) begin
        chk("vld_timing", 32'(O_SND_VLD), 32'(exp_vld));
        chk("queue_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          automatic exp_t e = q.pop_front();
          chk("snd", 32'(O_SND), 32'(e.snd));
          chk("clip", 32'(O_CLIP), 32'(e.clip));
        end
        pops++;
      end
    end
  end

  task automatic apply_vol();
    for (int k = 0; k < NCH; k++) I_VOL[4*k +: 4] = vol_m[k];
  endtask

  task automatic push_exp();
    int   s;
    exp_t e;
    s = 0;
    for (int k = 0; k < NCH; k++) s += (int'(hold_m[k]) - 128) * int'(vol_m[k]);
    s = s * (1 << GAIN_SH);
    if (mute_m) s = 0;
    else if (s > 32767)  begin s = 32767;  clip_m = 1; end
    else if (s < -32768) begin s = -32768; clip_m = 1; end
    e.snd  = 16'(s + 32768);
    e.clip = clip_m;
    q.push_back(e);
  endtask

  task automatic load(input logic [NCH-1:0] mask, input logic [7:0] val);
    for (int k = 0; k < NCH; k++)
      if (mask[k]) begin
        I_SMP[8*k +: 8] = val;
        hold_m[k] = val;
      end
    I_SMP_VLD = mask;
    @(negedge clk); #1;
    I_SMP_VLD = '0;
  endtask

  task automatic do_reset(input int n);
    I_RSTn = 1'b0;
    repeat (n) begin @(negedge clk); #1; end
    I_RSTn = 1'b1;
    q.delete();
    clip_m = 0;
    for (int k = 0; k < NCH; k++) hold_m[k] = 8'h80;
    chk("rst_snd", 32'(O_SND), 32'h8000);
    chk("rst_vld", 32'(O_SND_VLD), 32'd0);
    chk("rst_clip", 32'(O_CLIP), 32'd0);
    chk("rst_busy", 32'(O_BUSY), 32'd0);
  endtask

  task automatic wait_pulse();
    int p0 = pops;
    int n  = 0;
    while (pops == p0 && n < 2 * (DIV + 1) + 20) begin @(negedge clk); #1; n++; end
    chk("pulse_timeout", 32'(pops == p0), 32'd0);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(since_rst >= DIV && ((since_rst - DIV) % (DIV + 1)) == 0) && n < 2 * (DIV + 1));
    chk("tick_timeout", 32'(n >= 2 * (DIV + 1)), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin hold_m[k] = 8'h80; vol_m[k] = 4'd0; end
    I_SMP = {NCH{8'h80}};
    apply_vol();
    do_reset(3);
    mon_en = 1;

    // idle periods with silence on every channel
    push_exp(); push_exp();
    wait_pulse(); wait_pulse();

    // single channel at +64, full volume; check busy around the tick
    load(4'b0001, 8'hC0);
    vol_m[0] = 4'd15; apply_vol();
    push_exp();
    wait_tick();
    chk("busy_at_tick", 32'(O_BUSY), 32'd0);
    @(negedge clk); #1;
    chk("busy_in_acc", 32'(O_BUSY), 32'd1);
    wait_pulse();

    // positive and negative saturation, then silence with sticky clip
    for (int k = 0; k < NCH; k++) vol_m[k] = 4'd15;
    apply_vol();
    load('1, 8'hFF); push_exp(); wait_pulse();
    load('1, 8'h00); push_exp(); wait_pulse();
    load('1, 8'h80); push_exp(); wait_pulse();

    // mute overrides a saturating mix without setting clip; zero volume
    do_reset(1);
    mute_m = 1; I_MUTE = 1'b1;
    load('1, 8'hFF); push_exp(); wait_pulse();
    mute_m = 0; I_MUTE = 1'b0;
    load('1, 8'h80);
    load(4'b0010, 8'h40);
    vol_m[1] = 4'd0; apply_vol();
    push_exp(); wait_pulse();

    // strobe on the tick cycle is only used in the following period
    load(4'b0010, 8'h80);
    vol_m[1] = 4'd15; apply_vol();
    push_exp();
    wait_tick();
    load(4'b0001, 8'hC0);
    push_exp();
    wait_pulse(); wait_pulse();

    // reset in the middle of accumulation aborts that period
    wait_tick();
    @(negedge clk); #1;
    @(negedge clk); #1;
    do_reset(1);
    push_exp(); wait_pulse();
    load(4'b0001, 8'hC0);
    push_exp(); wait_pulse();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
